// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter giving two requesters timed SETUP/STROBE access to an 8-byte memory array.
// Ack comes 1+SETUP_CYCLES+STROBE_CYCLES cycles after grant; a requester holds its request until ack.
module mem_access_arbiter #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_a,
  input  logic       i_req_b,
  input  logic       i_we_a,
  input  logic       i_we_b,
  input  logic [2:0] i_addr_a,
  input  logic [2:0] i_addr_b,
  input  logic [7:0] i_wdata_a,
  input  logic [7:0] i_wdata_b,
  output logic       o_ack_a,
  output logic       o_ack_b,
  output logic [7:0] o_rdata_a,
  output logic [7:0] o_rdata_b,
  output logic [2:0] o_mem_adr,
  output logic       o_mem_valid,
  output logic       o_mem_rw,
  output logic [7:0] o_mem_din,
  input  logic [7:0] i_mem_dout,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] SETUP_LOAD  = 3'(SETUP_CYCLES - 1);
  localparam logic [2:0] STROBE_LOAD = 3'(STROBE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       owner_b_q, owner_b_d;
  logic       last_b_q, last_b_d;
  logic       we_q, we_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] din_q, din_d;
  logic [7:0] rdata_a_q, rdata_a_d;
  logic [7:0] rdata_b_q, rdata_b_d;

  logic grant;
  logic win_b;
  logic last_strobe;

  assign grant       = (state_q == IDLE) && (i_req_a || i_req_b);
  // With both requesting, B wins only when A was granted last.
  assign win_b       = i_req_b && (!i_req_a || !last_b_q);
  assign last_strobe = (state_q == STROBE) && (cnt_q == 3'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = SETUP;
          cnt_d   = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (cnt_q == 3'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 3'd0) begin
          state_d = DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    o_mem_valid = (state_q == STROBE);
    o_busy      = (state_q != IDLE);
    o_ack_a     = (state_q == DONE) && !owner_b_q;
    o_ack_b     = (state_q == DONE) && owner_b_q;
    o_mem_adr   = adr_q;
    o_mem_rw    = we_q;
    o_mem_din   = din_q;
    o_rdata_a   = rdata_a_q;
    o_rdata_b   = rdata_b_q;
  end

  // Request fields are captured only at grant so the bus is stable for the whole access.
  always_comb begin
    owner_b_d = owner_b_q;
    last_b_d  = last_b_q;
    we_d      = we_q;
    adr_d     = adr_q;
    din_d     = din_q;
    if (grant) begin
      owner_b_d = win_b;
      last_b_d  = win_b;
      we_d      = win_b ? i_we_b    : i_we_a;
      adr_d     = win_b ? i_addr_b  : i_addr_a;
      din_d     = win_b ? i_wdata_b : i_wdata_a;
    end
  end

  always_comb begin
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (last_strobe && !we_q) begin
      if (owner_b_q) rdata_b_d = i_mem_dout;
      else           rdata_a_d = i_mem_dout;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_b_q <= 1'b0;
      last_b_q  <= 1'b1;
      we_q      <= 1'b0;
      adr_q     <= 3'd0;
      din_q     <= 8'h00;
      rdata_a_q <= 8'h00;
      rdata_b_q <= 8'h00;
    end else begin
      owner_b_q <= owner_b_d;
      last_b_q  <= last_b_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      din_q     <= din_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_access_arbiter;

  localparam int S  = 1;
  localparam int T  = 2;
  localparam int S2 = 3;
  localparam int T2 = 1;

  logic       clk;
  logic       rst_n;
  logic       mem_clr;

  logic       req_a, req_b, we_a, we_b;
  logic [2:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       ack_a, ack_b;
  logic [7:0] rdata_a, rdata_b;
  logic [2:0] mem_adr;
  logic       mem_valid, mem_rw;
  logic [7:0] mem_din, mem_dout;
  logic       busy;

  logic       req2_a, req2_b, we2_a, we2_b;
  logic [2:0] addr2_a, addr2_b;
  logic [7:0] wdata2_a, wdata2_b;
  logic       ack2_a, ack2_b;
  logic [7:0] rdata2_a, rdata2_b;
  logic [2:0] mem2_adr;
  logic       mem2_valid, mem2_rw;
  logic [7:0] mem2_din, mem2_dout;
  logic       busy2;

  logic [7:0] mem [8];

  int n_vec = 0;
  int n_err = 0;

  logic       tr_valid [0:17];
  logic       tr_busy  [0:17];
  logic       tr_ack   [0:17];
  logic       tr_oack  [0:17];
  logic [2:0] tr_adr   [0:17];
  logic       tr_rw    [0:17];
  logic [7:0] tr_din   [0:17];

  mem_access_arbiter #(.SETUP_CYCLES(S), .STROBE_CYCLES(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_a(req_a), .i_req_b(req_b), .i_we_a(we_a), .i_we_b(we_b),
    .i_addr_a(addr_a), .i_addr_b(addr_b), .i_wdata_a(wdata_a), .i_wdata_b(wdata_b),
    .o_ack_a(ack_a), .o_ack_b(ack_b), .o_rdata_a(rdata_a), .o_rdata_b(rdata_b),
    .o_mem_adr(mem_adr), .o_mem_valid(mem_valid), .o_mem_rw(mem_rw), .o_mem_din(mem_din),
    .i_mem_dout(mem_dout), .o_busy(busy)
  );

  mem_access_arbiter #(.SETUP_CYCLES(S2), .STROBE_CYCLES(T2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_a(req2_a), .i_req_b(req2_b), .i_we_a(we2_a), .i_we_b(we2_b),
    .i_addr_a(addr2_a), .i_addr_b(addr2_b), .i_wdata_a(wdata2_a), .i_wdata_b(wdata2_b),
    .o_ack_a(ack2_a), .o_ack_b(ack2_b), .o_rdata_a(rdata2_a), .o_rdata_b(rdata2_b),
    .o_mem_adr(mem2_adr), .o_mem_valid(mem2_valid), .o_mem_rw(mem2_rw), .o_mem_din(mem2_din),
    .i_mem_dout(mem2_dout), .o_busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in memory array for the default-parameter instance.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    end else if (mem_valid && mem_rw) begin
      mem[mem_adr] <= mem_din;
    end
  end
  assign mem_dout  = mem[mem_adr];
  assign mem2_dout = 8'h5A;

  task automatic drive_idle();
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    req2_a = 0; req2_b = 0; we2_a = 0; we2_b = 0;
    addr2_a = 0; addr2_b = 0; wdata2_a = 0; wdata2_b = 0;
  endtask

  task automatic reset_dut();
    rst_n = 0; mem_clr = 1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1; mem_clr = 0;
  endtask

  // Issues one access, scrambles the requester's fields once it is in flight, and records a per-cycle trace.
  task automatic run_txn(input bit is_b, input bit we, input logic [2:0] adr, input logic [7:0] wd,
                         input bit drop_early, output int ack_c);
    if (is_b) begin req_b = 1; we_b = we; addr_b = adr; wdata_b = wd; end
    else      begin req_a = 1; we_a = we; addr_a = adr; wdata_a = wd; end
    ack_c = -1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      tr_valid[c] = mem_valid;
      tr_busy[c]  = busy;
      tr_adr[c]   = mem_adr;
      tr_rw[c]    = mem_rw;
      tr_din[c]   = mem_din;
      tr_ack[c]   = is_b ? ack_b : ack_a;
      tr_oack[c]  = is_b ? ack_a : ack_b;
      if (c == 1 && drop_early) begin
        if (is_b) req_b = 0; else req_a = 0;
      end
      if (c == 2) begin
        if (is_b) begin we_b = ~we; addr_b = ~adr; wdata_b = ~wd; end
        else      begin we_a = ~we; addr_a = ~adr; wdata_a = ~wd; end
      end
      if (tr_ack[c]) begin
        if (is_b) req_b = 0; else req_a = 0;
        ack_c = c;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; mem_clr = 1;
    drive_idle();
    #2;
    n_vec++;
    if ({busy, mem_valid, ack_a, ack_b, mem_rw} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000", {busy, mem_valid, ack_a, ack_b, mem_rw});
    end
    n_vec++;
    if ({mem_adr, mem_din} !== 11'h0) begin
      n_err++; $display("FAIL reset_bus: got adr=%h din=%h want 0", mem_adr, mem_din);
    end
    n_vec++;
    if ({rdata_a, rdata_b} !== 16'h0) begin
      n_err++; $display("FAIL reset_rdata: got a=%h b=%h want 00", rdata_a, rdata_b);
    end
    n_vec++;
    if ({busy2, mem2_valid, ack2_a, ack2_b, mem2_rw, mem2_adr, mem2_din, rdata2_a, rdata2_b} !== 32'h0) begin
      n_err++; $display("FAIL reset_dut2: got nonzero outputs busy=%b valid=%b", busy2, mem2_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1; mem_clr = 0;
  endtask

  task automatic test_write_read();
    int ac;
    logic exp_v;
    run_txn(0, 1, 3'd3, 8'hA5, 0, ac);
    n_vec++;
    if (ac !== 4) begin n_err++; $display("FAIL wr_ack_latency: got %0d want 4", ac); end
    for (int c = 1; c <= 4; c++) begin
      exp_v = (c == 2 || c == 3);
      n_vec++;
      if (tr_valid[c] !== exp_v || tr_busy[c] !== 1'b1 || tr_oack[c] !== 1'b0) begin
        n_err++; $display("FAIL wr_strobe c%0d: got v=%b busy=%b oack=%b want v=%b busy=1 oack=0",
                          c, tr_valid[c], tr_busy[c], tr_oack[c], exp_v);
      end
      n_vec++;
      if ({tr_rw[c], tr_adr[c], tr_din[c]} !== {1'b1, 3'd3, 8'hA5}) begin
        n_err++; $display("FAIL wr_bus c%0d: got rw=%b adr=%h din=%h want 1 3 a5", c, tr_rw[c], tr_adr[c], tr_din[c]);
      end
    end
    run_txn(0, 0, 3'd3, 8'h11, 0, ac);
    n_vec++;
    if (ac !== 4) begin n_err++; $display("FAIL rd_ack_latency: got %0d want 4", ac); end
    for (int c = 1; c <= 4; c++) begin
      exp_v = (c == 2 || c == 3);
      n_vec++;
      if (tr_valid[c] !== exp_v || {tr_rw[c], tr_adr[c]} !== {1'b0, 3'd3}) begin
        n_err++; $display("FAIL rd_strobe c%0d: got v=%b rw=%b adr=%h want v=%b rw=0 adr=3",
                          c, tr_valid[c], tr_rw[c], tr_adr[c], exp_v);
      end
    end
    n_vec++;
    if (rdata_a !== 8'hA5) begin n_err++; $display("FAIL rd_data_a: got %h want a5", rdata_a); end
  endtask

  task automatic test_hold_fields();
    int ac;
    run_txn(1, 1, 3'd7, 8'h3C, 0, ac);
    run_txn(1, 0, 3'd7, 8'h00, 0, ac);
    n_vec++;
    if (ac !== 4) begin n_err++; $display("FAIL b_ack_latency: got %0d want 4", ac); end
    for (int c = 1; c <= 4; c++) begin
      n_vec++;
      if ({tr_rw[c], tr_adr[c]} !== {1'b0, 3'd7}) begin
        n_err++; $display("FAIL b_hold c%0d: got rw=%b adr=%h want rw=0 adr=7", c, tr_rw[c], tr_adr[c]);
      end
    end
    n_vec++;
    if (rdata_b !== 8'h3C) begin n_err++; $display("FAIL b_rdata: got %h want 3c", rdata_b); end
    n_vec++;
    if (rdata_a !== 8'hA5) begin n_err++; $display("FAIL a_rdata_kept: got %h want a5", rdata_a); end
  endtask

  task automatic test_drop_early();
    int ac;
    run_txn(0, 1, 3'd5, 8'h77, 1, ac);
    n_vec++;
    if (ac !== 4) begin n_err++; $display("FAIL drop_ack: got %0d want 4", ac); end
    n_vec++;
    if (rdata_a !== 8'hA5) begin n_err++; $display("FAIL write_keeps_rdata: got %h want a5", rdata_a); end
    run_txn(0, 0, 3'd5, 8'h00, 0, ac);
    n_vec++;
    if (rdata_a !== 8'h77) begin n_err++; $display("FAIL drop_readback: got %h want 77", rdata_a); end
  endtask

  task automatic test_reset_mid();
    req_a = 1; we_a = 1; addr_a = 3'd2; wdata_a = 8'hC3;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (mem_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_strobe: got %b want 1", mem_valid); end
    #1 rst_n = 0; req_a = 0;
    #1;
    n_vec++;
    if ({mem_valid, busy, ack_a, ack_b} !== 4'b0) begin
      n_err++; $display("FAIL mid_async: got v/busy/acks=%b want 0000", {mem_valid, busy, ack_a, ack_b});
    end
    n_vec++;
    if ({mem_rw, mem_adr, mem_din, rdata_a} !== 20'h0) begin
      n_err++; $display("FAIL mid_clear: got rw=%b adr=%h din=%h rdata_a=%h want 0", mem_rw, mem_adr, mem_din, rdata_a);
    end
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, ack_a} !== 2'b0) begin
        n_err++; $display("FAIL mid_no_retry c%0d: got busy=%b ack_a=%b want 0 0", c, busy, ack_a);
      end
    end
  endtask

  task automatic test_arbitration();
    int order [$];
    int acyc  [$];
    reset_dut();
    req_a = 1; we_a = 0; addr_a = 3'd1;
    req_b = 1; we_b = 0; addr_b = 3'd2;
    for (int c = 1; c <= 40 && order.size() < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (ack_a && ack_b) begin n_err++; $display("FAIL arb_dual_ack c%0d: got 11 want at most one", c); end
      if (ack_a) begin order.push_back(0); acyc.push_back(c); end
      if (ack_b) begin order.push_back(1); acyc.push_back(c); end
    end
    req_a = 0; req_b = 0;
    n_vec++;
    if (order.size() !== 4) begin n_err++; $display("FAIL arb_count: got %0d want 4", order.size()); end
    for (int i = 0; i < order.size(); i++) begin
      n_vec++;
      if (order[i] !== (i % 2)) begin
        n_err++; $display("FAIL arb_order %0d: got %s want %s", i, order[i] ? "B" : "A", (i % 2) ? "B" : "A");
      end
      n_vec++;
      if (i == 0 && acyc[i] !== S + T + 1) begin
        n_err++; $display("FAIL arb_first_ack: got %0d want %0d", acyc[i], S + T + 1);
      end else if (i > 0 && acyc[i] - acyc[i-1] !== S + T + 2) begin
        n_err++; $display("FAIL arb_spacing %0d: got %0d want %0d", i, acyc[i] - acyc[i-1], S + T + 2);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_setup3();
    logic exp_v, exp_ack;
    req2_a = 1; we2_a = 0; addr2_a = 3'd6; wdata2_a = 8'h99;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      exp_v   = (c >= S2 + 1 && (c - (S2 + 1)) % (S2 + T2 + 2) == 0);
      exp_ack = (c >= S2 + T2 + 1 && (c - (S2 + T2 + 1)) % (S2 + T2 + 2) == 0);
      n_vec++;
      if (mem2_valid !== exp_v || ack2_a !== exp_ack || ack2_b !== 1'b0) begin
        n_err++; $display("FAIL s3_timing c%0d: got v=%b ack_a=%b ack_b=%b want v=%b ack_a=%b ack_b=0",
                          c, mem2_valid, ack2_a, ack2_b, exp_v, exp_ack);
      end
      if (c == 24) req2_a = 0;
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy2 !== 1'b0 || rdata2_a !== 8'h5A || rdata2_b !== 8'h00) begin
      n_err++; $display("FAIL s3_final: got busy=%b rdata_a=%h rdata_b=%h want 0 5a 00", busy2, rdata2_a, rdata2_b);
    end
    n_vec++;
    if ({mem2_rw, mem2_adr, mem2_din} !== {1'b0, 3'd6, 8'h99}) begin
      n_err++; $display("FAIL s3_bus: got rw=%b adr=%h din=%h want 0 6 99", mem2_rw, mem2_adr, mem2_din);
    end
  endtask

  // Transaction model: a grant at edge g puts STROBE in cycles g+S+1..g+S+T, ack in g+S+T+1,
  // and the next grant can happen no earlier than the edge ending cycle g+S+T+2.
  task automatic test_random();
    int g, free, done_c;
    bit has, own_b, last_b, m_we;
    logic [2:0] m_adr;
    logic [7:0] m_din, rd_a, rd_b;
    logic [7:0] mm [8];
    logic e_busy, e_valid, e_ack_a, e_ack_b;
    reset_dut();
    g = 0; free = 0; has = 0; own_b = 0; last_b = 0;
    m_we = 0; m_adr = 0; m_din = 0; rd_a = 0; rd_b = 0;
    for (int i = 0; i < 8; i++) mm[i] = 8'h00;
    for (int k = 0; k < 400; k++) begin
      done_c  = g + S + T + 1;
      e_busy  = has && k > g && k <= done_c;
      e_valid = has && k > g + S && k <= g + S + T;
      e_ack_a = has && k == done_c && !own_b;
      e_ack_b = has && k == done_c && own_b;
      if (has && k == done_c) begin
        if (m_we) mm[m_adr] = m_din;
        else if (own_b) rd_b = mm[m_adr];
        else rd_a = mm[m_adr];
      end
      n_vec++;
      if ({busy, mem_valid, ack_a, ack_b} !== {e_busy, e_valid, e_ack_a, e_ack_b}) begin
        n_err++; $display("FAIL rnd_ctrl k%0d: got busy/v/aa/ab=%b want %b", k,
                          {busy, mem_valid, ack_a, ack_b}, {e_busy, e_valid, e_ack_a, e_ack_b});
      end
      n_vec++;
      if ({rdata_a, rdata_b} !== {rd_a, rd_b}) begin
        n_err++; $display("FAIL rnd_rdata k%0d: got a=%h b=%h want a=%h b=%h", k, rdata_a, rdata_b, rd_a, rd_b);
      end
      n_vec++;
      if ({mem_rw, mem_adr, mem_din} !== {m_we, m_adr, m_din}) begin
        n_err++; $display("FAIL rnd_bus k%0d: got rw=%b adr=%h din=%h want rw=%b adr=%h din=%h",
                          k, mem_rw, mem_adr, mem_din, m_we, m_adr, m_din);
      end
      if (has && g == k - 1 && !own_b) begin
        if ($urandom_range(1) == 1) begin addr_a = 3'($urandom_range(7)); wdata_a = 8'($urandom); we_a = ~we_a; end
        if ($urandom_range(3) == 0) req_a = 0;
      end else if (e_ack_a) begin
        req_a = 0;
      end else if (!req_a && $urandom_range(2) == 0) begin
        req_a = 1; we_a = 1'($urandom); addr_a = 3'($urandom_range(7)); wdata_a = 8'($urandom);
      end
      if (has && g == k - 1 && own_b) begin
        if ($urandom_range(1) == 1) begin addr_b = 3'($urandom_range(7)); wdata_b = 8'($urandom); we_b = ~we_b; end
        if ($urandom_range(3) == 0) req_b = 0;
      end else if (e_ack_b) begin
        req_b = 0;
      end else if (!req_b && $urandom_range(2) == 0) begin
        req_b = 1; we_b = 1'($urandom); addr_b = 3'($urandom_range(7)); wdata_b = 8'($urandom);
      end
      if (k >= free && (req_a || req_b)) begin
        if (req_a && req_b) own_b = !last_b;
        else own_b = req_b;
        last_b = own_b;
        has    = 1;
        g      = k;
        free   = k + S + T + 2;
        m_we   = own_b ? we_b    : we_a;
        m_adr  = own_b ? addr_b  : addr_a;
        m_din  = own_b ? wdata_b : wdata_a;
      end
      @(posedge clk);
      @(negedge clk);
    end
    req_a = 0; req_b = 0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hold_fields();
    test_drop_early();
    test_reset_mid();
    test_arbitration();
    test_setup3();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
